// File: rtl/picosoc_regs_pkg.sv
// Shared types and constants for the PicoSoC register-file write buffer.
package picosoc_regs_pkg;

    localparam int XLEN          = 32;
    localparam int REG_IDX_W     = 6;
    localparam int REG_SEL_W     = 5;
    localparam int DEPTH_DEFAULT = 4;

    // What register-file port A does in a given cycle
    typedef enum logic [1:0] {
        PORT_IDLE,
        PORT_DRAIN,
        PORT_READ
    } port_op_e;

    // One buffered write: only the significant register-select bits are kept
    typedef struct packed {
        logic [REG_SEL_W-1:0] sel;
        logic [XLEN-1:0]      data;
    } wbuf_entry_t;

    // Register index zero is hard-wired to zero; the upper index bit is ignored
    function automatic logic is_zero_reg(input logic [REG_IDX_W-1:0] idx);
        return idx[REG_SEL_W-1:0] == '0;
    endfunction

endpackage

// File: rtl/picosoc_regs_wbuf_cam.sv
// In-order write-buffer storage with two newest-match lookup ports.
// Entries are kept oldest-first from rd_ptr; a lookup scans from oldest to
// newest so the last match found is the youngest write to that register.
module picosoc_regs_wbuf_cam
    import picosoc_regs_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 push,
    input  logic [REG_SEL_W-1:0] push_sel,
    input  logic [XLEN-1:0]      push_data,
    input  logic                 pop,
    output logic [REG_SEL_W-1:0] head_sel,
    output logic [XLEN-1:0]      head_data,
    output logic                 full,
    output logic                 empty,
    input  logic [REG_SEL_W-1:0] lk_sel1,
    output logic                 lk_hit1,
    output logic [XLEN-1:0]      lk_data1,
    input  logic [REG_SEL_W-1:0] lk_sel2,
    output logic                 lk_hit2,
    output logic [XLEN-1:0]      lk_data2
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    wbuf_entry_t    slots [DEPTH];
    logic [PW-1:0]  wr_ptr;
    logic [PW-1:0]  rd_ptr;
    logic [CW-1:0]  count;
    logic [PW-1:0]  scan_idx;

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Payload storage needs no reset: occupancy alone decides what is valid
    always_ff @(posedge clk) begin
        if (push) begin
            slots[wr_ptr] <= '{sel: push_sel, data: push_data};
        end
    end

    assign full      = (count == CW'(DEPTH));
    assign empty     = (count == '0);
    assign head_sel  = slots[rd_ptr].sel;
    assign head_data = slots[rd_ptr].data;

    // Oldest-to-newest scan so the youngest matching entry wins
    always_comb begin
        lk_hit1  = 1'b0;
        lk_data1 = '0;
        lk_hit2  = 1'b0;
        lk_data2 = '0;
        scan_idx = '0;
        for (int k = 0; k < DEPTH; k++) begin
            scan_idx = rd_ptr + PW'(k);
            if (CW'(k) < count) begin
                if (slots[scan_idx].sel == lk_sel1) begin
                    lk_hit1  = 1'b1;
                    lk_data1 = slots[scan_idx].data;
                end
                if (slots[scan_idx].sel == lk_sel2) begin
                    lk_hit2  = 1'b1;
                    lk_data2 = slots[scan_idx].data;
                end
            end
        end
    end

endmodule

// File: rtl/picosoc_regs_wbuf.sv
// Register-file front end with a posted write buffer.
// Writes are queued and drained to the register file when port A is free;
// reads take priority unless the buffer is full.
// Optional feature macro PICOSOC_REGS_WBUF_FWD_EN: when defined, reads of
// buffered registers are forwarded from the buffer; otherwise such reads
// stall until the conflicting entries have drained.
module picosoc_regs_wbuf
    import picosoc_regs_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 wr_req,
    input  logic [REG_IDX_W-1:0] wr_addr,
    input  logic [XLEN-1:0]      wr_data,
    output logic                 wr_ready,
    input  logic                 rd_req,
    input  logic [REG_IDX_W-1:0] rd_addr1,
    input  logic [REG_IDX_W-1:0] rd_addr2,
    output logic                 rd_ready,
    output logic                 rd_valid,
    output logic [XLEN-1:0]      rd_data1,
    output logic [XLEN-1:0]      rd_data2,
    output logic                 rf_wen,
    output logic [REG_IDX_W-1:0] rf_waddr,
    output logic [REG_IDX_W-1:0] rf_raddr1,
    output logic [REG_IDX_W-1:0] rf_raddr2,
    output logic [XLEN-1:0]      rf_wdata,
    input  logic [XLEN-1:0]      rf_rdata1,
    input  logic [XLEN-1:0]      rf_rdata2
);

    logic                 full;
    logic                 empty;
    logic [REG_SEL_W-1:0] head_sel;
    logic [XLEN-1:0]      head_data;
    logic                 hit1;
    logic                 hit2;
    logic [XLEN-1:0]      hit_data1;
    logic [XLEN-1:0]      hit_data2;
    logic                 hazard;
    logic                 push;
    logic                 pop;
    logic                 read_go;
    port_op_e             port_op;

    logic                 rsp_zero1;
    logic                 rsp_zero2;
    logic                 rsp_fwd1;
    logic                 rsp_fwd2;
    logic [XLEN-1:0]      rsp_fwd_data1;
    logic [XLEN-1:0]      rsp_fwd_data2;
    logic [XLEN-1:0]      last_data1;
    logic [XLEN-1:0]      last_data2;
    logic                 unused_bits;

    picosoc_regs_wbuf_cam #(
        .DEPTH (DEPTH)
    ) u_cam (
        .clk       (clk),
        .resetn    (resetn),
        .push      (push),
        .push_sel  (wr_addr[REG_SEL_W-1:0]),
        .push_data (wr_data),
        .pop       (pop),
        .head_sel  (head_sel),
        .head_data (head_data),
        .full      (full),
        .empty     (empty),
        .lk_sel1   (rd_addr1[REG_SEL_W-1:0]),
        .lk_hit1   (hit1),
        .lk_data1  (hit_data1),
        .lk_sel2   (rd_addr2[REG_SEL_W-1:0]),
        .lk_hit2   (hit2),
        .lk_data2  (hit_data2)
    );

`ifdef PICOSOC_REGS_WBUF_FWD_EN
    // Buffered values are forwarded, so a pending write never blocks a read
    assign hazard      = 1'b0;
    assign unused_bits = wr_addr[REG_IDX_W-1];
`else
    // Without forwarding a read must wait until its non-zero operands drain
    assign hazard      = (!is_zero_reg(rd_addr1) && hit1) ||
                         (!is_zero_reg(rd_addr2) && hit2);
    assign unused_bits = ^{wr_addr[REG_IDX_W-1], hit_data1, hit_data2};
`endif

    // A drain in the same cycle only frees a slot once the count updates
    assign wr_ready = !full;
    assign rd_ready = resetn && !full && !hazard;
    assign push     = wr_req && wr_ready && !is_zero_reg(wr_addr);

    // Port A arbitration: a full buffer forces a drain, else reads go first
    always_comb begin
        port_op = PORT_IDLE;
        if (rd_req && rd_ready) begin
            port_op = PORT_READ;
        end else if (!empty) begin
            port_op = PORT_DRAIN;
        end
    end

    assign read_go = (port_op == PORT_READ);
    assign pop     = (port_op == PORT_DRAIN);

    // Drive the shared register-file port; unused fields rest at zero
    always_comb begin
        rf_wen    = 1'b0;
        rf_waddr  = '0;
        rf_wdata  = '0;
        rf_raddr1 = '0;
        rf_raddr2 = '0;
        if (port_op == PORT_DRAIN) begin
            rf_wen   = 1'b1;
            rf_waddr = {1'b0, head_sel};
            rf_wdata = head_data;
        end else if (port_op == PORT_READ) begin
            rf_raddr1 = rd_addr1;
            rf_raddr2 = rd_addr2;
        end
    end

    // Capture how each operand will be resolved when the register file answers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rd_valid      <= 1'b0;
            rsp_zero1     <= 1'b0;
            rsp_zero2     <= 1'b0;
            rsp_fwd1      <= 1'b0;
            rsp_fwd2      <= 1'b0;
            rsp_fwd_data1 <= '0;
            rsp_fwd_data2 <= '0;
            last_data1    <= '0;
            last_data2    <= '0;
        end else begin
            rd_valid <= read_go;
            if (read_go) begin
                rsp_zero1 <= is_zero_reg(rd_addr1);
                rsp_zero2 <= is_zero_reg(rd_addr2);
`ifdef PICOSOC_REGS_WBUF_FWD_EN
                rsp_fwd1      <= hit1;
                rsp_fwd2      <= hit2;
                rsp_fwd_data1 <= hit_data1;
                rsp_fwd_data2 <= hit_data2;
`else
                rsp_fwd1      <= 1'b0;
                rsp_fwd2      <= 1'b0;
                rsp_fwd_data1 <= '0;
                rsp_fwd_data2 <= '0;
`endif
            end
            if (rd_valid) begin
                last_data1 <= rd_data1;
                last_data2 <= rd_data2;
            end
        end
    end

    // Operands resolve zero register first, then forwarded data, then the file
    always_comb begin
        rd_data1 = last_data1;
        rd_data2 = last_data2;
        if (rd_valid) begin
            rd_data1 = rsp_zero1 ? '0 : (rsp_fwd1 ? rsp_fwd_data1 : rf_rdata1);
            rd_data2 = rsp_zero2 ? '0 : (rsp_fwd2 ? rsp_fwd_data2 : rf_rdata2);
        end
    end

endmodule

// File: doc/picosoc_regs_wbuf.md
PICOSOC_REGS_WBUF -- requirements
Module: picosoc_regs_wbuf

Interface
REQ-001 Parameter DEPTH, default 4, write-buffer entries, power of two, 2..8.
REQ-002 clk  input  1  single clock; all state on rising edge.
REQ-003 resetn  input  1  asynchronous, active-low reset.
REQ-004 wr_req  input  1  core write request.
REQ-005 wr_addr  input  6  write register index; only [4:0] significant.
REQ-006 wr_data  input  32  write data.
REQ-007 wr_ready  output  1  write accepted when wr_req && wr_ready.
REQ-008 rd_req  input  1  core read request, two operands.
REQ-009 rd_addr1, rd_addr2  input  6 each  read indices; only [4:0] significant.
REQ-010 rd_ready  output  1  read accepted when rd_req && rd_ready.
REQ-011 rd_valid  output  1  pulses one cycle after each accepted read.
REQ-012 rd_data1, rd_data2  output  32 each  operands; valid while rd_valid.
REQ-013 rf_wen, rf_waddr[5:0], rf_raddr1[5:0], rf_raddr2[5:0], rf_wdata[31:0]  output  register-file port; rf_rdata1, rf_rdata2 [31:0] input; 1-cycle read latency.

Function
REQ-014 Accepted writes with wr_addr[4:0]==0 are discarded; no buffer entry.
REQ-015 Other accepted writes enter an in-order FIFO of DEPTH entries.
REQ-016 wr_ready = !full; a drain in the same cycle does not free a slot until the next cycle.
REQ-017 Register-file port A is shared: a cycle either drains one entry (rf_wen=1, rf_waddr/rf_wdata = FIFO head) or issues a read (rf_wen=0, rf_raddr1/2 = rd_addr1/2); never both.
REQ-018 Arbitration: FIFO full -> drain, rd_ready=0; else rd_req -> read, rd_ready=1; else FIFO non-empty -> drain; else idle.
REQ-019 When not full, rd_ready=1 combinationally regardless of rd_req.
REQ-020 Read accepted in cycle T -> rd_valid=1 in T+1 with rd_data from rf_rdata unless overridden (REQ-021, REQ-022).
REQ-021 Operand index 0 returns 32'h0.
REQ-022 Forwarding: an operand index matching a buffered entry at T returns the newest matching entry's data, captured at T.
REQ-023 A write accepted in the same cycle as a read is ordered after it; the read returns the prior value.
REQ-024 rd_data1/2 hold their last value when rd_valid=0.
REQ-025 FIFO pointers wrap modulo DEPTH; empty/full from a count register of clog2(DEPTH)+1 bits.

Reset
REQ-026 resetn low: FIFO empty, rd_valid=0, rd_data1/2=0, rf_wen=0, rf_waddr/rf_raddr1/rf_raddr2/rf_wdata=0; wr_ready=1 and rd_ready=1 after release.
REQ-027 Reset mid-operation discards buffered writes; no drain completes after resetn falls.

Configuration
REQ-028 Macro PICOSOC_REGS_WBUF_FWD_EN defined: forwarding per REQ-022.
REQ-029 Undefined: no forwarding; rd_ready=0 while either non-zero operand index matches any buffered entry; drains continue until clear.

Structure
REQ-030 Package picosoc_regs_pkg holds XLEN=32, REG_IDX_W=6, REG_SEL_W=5, DEPTH_DEFAULT=4.
REQ-031 Sub-module picosoc_regs_wbuf_cam: FIFO storage, pointers, count, two newest-match lookup ports (hit, data).

Verification
REQ-032 Write r5=0x11111111 then immediate read r5,r0 -> rd_valid next cycle, rd_data1=0x11111111 (forwarded), rd_data2=0.
REQ-033 Writes r3=A, r3=B back-to-back, read r3 before drain -> rd_data1=B (newest entry).
REQ-034 DEPTH=4, 4 writes with rd_req held high -> wr_ready=0 when full, rd_ready=0, one drain occurs, then read accepted.
REQ-035 Write r0=0xDEADBEEF -> no rf_wen pulse; later read r0 -> 0.
REQ-036 Same-cycle write r7=0x5 and read r7 (r7 previously 0x9) -> rd_data1=0x9; next read -> 0x5.
REQ-037 resetn low with 3 entries buffered -> no further rf_wen; after release read of those registers returns pre-write values; FWD_EN undefined run repeats REQ-032 showing rd_ready=0 until drain.
